mem_copy_dma: RTL and testbench

- Block-copy DMA engine; the initiator side of the single-cycle word memory interface (mem_valid/mem_write/mem_addr/mem_wdata/mem_rdata) served by the on-chip RAM.
- Software or the CPU supplies source, destination and length, then pulses start.
- The engine alternates read and write accesses until the word count is exhausted, then pulses done.
- Overlapping ranges copy with memmove semantics.

---
 rtl/mem_copy_dma.sv | 149 ++++++++++++++
 tb/tb_mem_copy_dma.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// Block-copy DMA engine: reads a word, writes it, repeats until the word count
// is exhausted. Overlapping ranges are copied back-to-front when needed so the
// result matches memmove. Memory strobes decode only registered state/pointers.
module mem_copy_dma #(
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 19,
   parameter int MEM_WORDS = 262144
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] words_done,
   output logic              mem_valid,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Range limit widened by one bit so src+len never wraps during the check.
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_src_ptr;
   logic [ADDR_W-1:0] r_dst_ptr;
   logic [ADDR_W-1:0] r_remaining;
   logic [ADDR_W-1:0] r_words_done;
   logic              r_down;
   logic              r_error;

   logic [ADDR_W:0]   w_src_end;
   logic [ADDR_W:0]   w_dst_end;
   logic              w_range_err;
   logic              w_len_zero;
   logic              w_overlap_down;
   logic              w_accept;
   logic              w_last_word;

   assign w_src_end      = {1'b0, src_addr} + {1'b0, len};
   assign w_dst_end      = {1'b0, dst_addr} + {1'b0, len};
   assign w_range_err    = (w_src_end > MEM_LIMIT) || (w_dst_end > MEM_LIMIT);
   assign w_len_zero     = (len == '0);
   // Destination starts inside the source range above its base: copy from the top
   // down so no source word is overwritten before it has been read.
   assign w_overlap_down = (dst_addr > src_addr) && ({1'b0, dst_addr} < w_src_end);
   assign w_accept       = (r_state == ST_IDLE) && start;
   assign w_last_word    = (r_remaining == ADDR_W'(1));
   assign words_done     = r_words_done;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and output strobes, all derived from the registered state.
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      error        = 1'b0;
      mem_valid    = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = (w_range_err || w_len_zero) ? ST_FIN : ST_RD;
            end
         end
         ST_RD: begin
            busy         = 1'b1;
            mem_valid    = 1'b1;
            mem_addr     = r_src_ptr;
            w_state_next = abort ? ST_FIN : ST_WR;
         end
         ST_WR: begin
            busy         = 1'b1;
            mem_valid    = 1'b1;
            mem_write    = 1'b1;
            mem_addr     = r_dst_ptr;
            mem_wdata    = mem_rdata;
            w_state_next = (abort || w_last_word) ? ST_FIN : ST_RD;
         end
         ST_FIN: begin
            done         = 1'b1;
            error        = r_error;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Pointer, count and status registers: loaded on an accepted start, stepped on each write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_ptr    <= '0;
         r_dst_ptr    <= '0;
         r_remaining  <= '0;
         r_words_done <= '0;
         r_down       <= 1'b0;
         r_error      <= 1'b0;
      end else if (w_accept) begin
         r_error      <= w_range_err;
         r_words_done <= '0;
         r_remaining  <= len;
         r_down       <= w_overlap_down;
         if (w_overlap_down) begin
            r_src_ptr <= w_src_end[ADDR_W-1:0] - ADDR_W'(1);
            r_dst_ptr <= w_dst_end[ADDR_W-1:0] - ADDR_W'(1);
         end else begin
            r_src_ptr <= src_addr;
            r_dst_ptr <= dst_addr;
         end
      end else if (r_state == ST_WR) begin
         r_words_done <= r_words_done + ADDR_W'(1);
         r_remaining  <= r_remaining - ADDR_W'(1);
         if (r_down) begin
            r_src_ptr <= r_src_ptr - ADDR_W'(1);
            r_dst_ptr <= r_dst_ptr - ADDR_W'(1);
         end else begin
            r_src_ptr <= r_src_ptr + ADDR_W'(1);
            r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Testbench for mem_copy_dma: a RAM model with registered read serves the DMA,
// and a memmove-style reference predicts accesses, timing and final memory.
module tb_mem_copy_dma;
   localparam int ADDR_W    = 19;
   localparam int DATA_W    = 19;
   localparam int MEM_WORDS = 262144;
   localparam int MW        = 18;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] src_addr = '0;
   logic [ADDR_W-1:0] dst_addr = '0;
   logic [ADDR_W-1:0] len = '0;
   logic              busy, done, error;
   logic [ADDR_W-1:0] words_done;
   logic              mem_valid, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   bit   [DATA_W-1:0] ram     [MEM_WORDS];
   bit   [DATA_W-1:0] ref_mem [MEM_WORDS];
   logic              bd_we = 1'b0;
   logic [MW-1:0]     bd_addr = '0;
   logic [DATA_W-1:0] bd_data = '0;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int          cyc;
      logic        wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } acc_t;

   mem_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .error(error), .words_done(words_done),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: registered read data, writes on the clock edge, plus a backdoor loader.
   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_addr] <= bd_data;
      end else if (mem_valid && (mem_addr < ADDR_W'(MEM_WORDS))) begin
         if (mem_write) ram[mem_addr[MW-1:0]] <= mem_wdata;
         else           mem_rdata <= ram[mem_addr[MW-1:0]];
      end
   end

   task automatic preload(input int addr, input logic [DATA_W-1:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = MW'(addr); bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
      ref_mem[addr] = d;
   endtask

   task automatic preload_rand(input int addr, input int n);
      for (int i = 0; i < n; i++) preload(addr + i, DATA_W'($urandom));
   endtask

   function automatic int mem_diffs(output int first);
      int d = 0;
      first = -1;
      for (int a = 0; a < MEM_WORDS; a++) begin
         if (ram[a] !== ref_mem[a]) begin
            if (first < 0) first = a;
            d++;
         end
      end
      return d;
   endfunction

   // One transfer against the reference. abort_cyc: cycle in which abort is held (0 = none).
   task automatic run_copy(input string name, input int src, input int dst, input int n,
                           input int abort_cyc, input bit abort_at_start, input bit noise);
      bit   exp_err, moves, desc;
      int   n_acc, exp_words, exp_done_cyc, budget, cyc, done_cyc, busy_cnt, first, nd;
      logic got_err;
      logic [ADDR_W-1:0] got_words;
      logic [DATA_W-1:0] snap [];
      acc_t exp_q[$];
      acc_t obs_q[$];
      acc_t e;
      // Reference: memmove of n words, truncated at the abort point.
      exp_err      = (src + n > MEM_WORDS) || (dst + n > MEM_WORDS);
      moves        = !exp_err && (n > 0);
      desc         = (dst > src) && (dst < src + n);
      n_acc        = !moves ? 0 : ((abort_cyc > 0) ? abort_cyc : 2 * n);
      exp_words    = n_acc / 2;
      exp_done_cyc = n_acc + 1;
      if (moves) begin
         snap = new[n];
         for (int j = 0; j < n; j++) snap[j] = ref_mem[src + j];
      end
      for (int k = 0; k < n_acc; k++) begin
         int j;
         j      = desc ? (n - 1 - k / 2) : (k / 2);
         e.cyc  = k + 1;
         e.wr   = (k % 2) == 1;
         e.addr = ADDR_W'(e.wr ? dst + j : src + j);
         e.data = e.wr ? snap[j] : '0;
         exp_q.push_back(e);
         if (e.wr) ref_mem[dst + j] = snap[j];
      end

      @(negedge clk);
      src_addr = ADDR_W'(src); dst_addr = ADDR_W'(dst); len = ADDR_W'(n);
      start = 1'b1; abort = abort_at_start;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      cyc = 1; done_cyc = 0; busy_cnt = 0; got_err = 1'b0; got_words = '0;
      budget = exp_done_cyc + 8;
      forever begin
         if (mem_valid) begin
            e.cyc = cyc; e.wr = mem_write; e.addr = mem_addr;
            e.data = mem_write ? mem_wdata : '0;
            obs_q.push_back(e);
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cyc = cyc; got_err = error; got_words = words_done;
            break;
         end
         if (cyc >= budget) break;
         abort = (cyc == abort_cyc);
         if (noise) begin
            start    = ($urandom_range(0, 2) == 0);
            src_addr = ADDR_W'($urandom);
            dst_addr = ADDR_W'($urandom);
            len      = ADDR_W'($urandom_range(0, 40));
         end
         @(negedge clk);
         cyc++;
      end
      abort = 1'b0;
      // A start presented during the completion cycle must be ignored.
      start = noise; src_addr = '0; dst_addr = ADDR_W'(1); len = ADDR_W'(1);
      @(negedge clk);
      start = 1'b0;

      n_total++;
      if (done_cyc !== exp_done_cyc) $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done_cyc);
      else n_pass++;
      n_total++;
      if (got_err !== exp_err) $display("FAIL %s error: got %0b expected %0b", name, got_err, exp_err);
      else n_pass++;
      n_total++;
      if (got_words !== ADDR_W'(exp_words)) $display("FAIL %s words_done: got %0d expected %0d", name, got_words, exp_words);
      else n_pass++;
      n_total++;
      if (busy_cnt !== n_acc) $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, n_acc);
      else n_pass++;
      n_total++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL %s access_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_total++;
         if (obs_q[k].cyc !== exp_q[k].cyc || obs_q[k].wr !== exp_q[k].wr ||
             obs_q[k].addr !== exp_q[k].addr || obs_q[k].data !== exp_q[k].data)
            $display("FAIL %s access[%0d]: got cyc%0d wr%0b a%0h d%0h expected cyc%0d wr%0b a%0h d%0h",
                     name, k, obs_q[k].cyc, obs_q[k].wr, obs_q[k].addr, obs_q[k].data,
                     exp_q[k].cyc, exp_q[k].wr, exp_q[k].addr, exp_q[k].data);
         else n_pass++;
      end
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_valid !== 1'b0)
         $display("FAIL %s idle_after_done: got busy%0b done%0b valid%0b expected 0 0 0", name, busy, done, mem_valid);
      else n_pass++;
      nd = mem_diffs(first);
      n_total++;
      if (nd !== 0) $display("FAIL %s memory: %0d words differ, first at %0h (got %0h expected %0h)",
                             name, nd, first, ram[first], ref_mem[first]);
      else n_pass++;
      $display("txn %s src=%0h dst=%0h len=%0d abort_cyc=%0d done_cyc=%0d words=%0d err=%0b",
               name, src, dst, n, abort_cyc, done_cyc, got_words, got_err);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_total++;
      if ({busy, done, error, mem_valid, mem_write} !== 5'b0 || words_done !== '0 ||
          mem_addr !== '0 || mem_wdata !== '0)
         $display("FAIL reset_outputs: got busy%0b done%0b err%0b v%0b w%0b wd%0h a%0h d%0h expected all 0",
                  busy, done, error, mem_valid, mem_write, words_done, mem_addr, mem_wdata);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      $display("txn reset released");
   endtask

   task automatic test_basic_copy;
      for (int i = 0; i < 4; i++) preload(32'h100 + i, DATA_W'(32'h10 + i));
      run_copy("basic", 32'h100, 32'h200, 4, 0, 1'b0, 1'b0);
   endtask

   task automatic test_len_zero;
      run_copy("len_zero", 32'h300, 32'h400, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_overlap;
      for (int i = 0; i < 5; i++) preload(32'h100 + i, DATA_W'(i + 1));
      run_copy("overlap_down", 32'h100, 32'h102, 5, 0, 1'b0, 1'b0);
      preload_rand(32'h800, 6);
      run_copy("overlap_up", 32'h800, 32'h7FE, 6, 0, 1'b0, 1'b0);
   endtask

   task automatic test_range_error;
      run_copy("range_src", 32'h3FFFE, 32'h10, 3, 0, 1'b0, 1'b0);
      run_copy("range_dst", 32'h10, 32'h3FFFF, 2, 0, 1'b0, 1'b0);
      run_copy("range_carry", 32'h1, 32'h20, 32'h7FFFF, 0, 1'b0, 1'b0);
      preload_rand(32'h3FFFC, 4);
      run_copy("range_exact", 32'h3FFFC, 32'h1000, 4, 0, 1'b0, 1'b0);
   endtask

   task automatic test_abort;
      preload_rand(32'h2000, 8);
      run_copy("abort_wr3", 32'h2000, 32'h3000, 8, 6, 1'b0, 1'b0);
      run_copy("abort_rd3", 32'h2000, 32'h3100, 8, 5, 1'b0, 1'b0);
      run_copy("after_abort", 32'h2000, 32'h3200, 8, 0, 1'b0, 1'b0);
      run_copy("abort_with_start", 32'h2000, 32'h3300, 3, 0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid;
      logic [DATA_W-1:0] w0;
      int nd, first;
      preload_rand(32'h500, 8);
      w0 = ref_mem[32'h500];
      @(negedge clk);
      src_addr = ADDR_W'(32'h500); dst_addr = ADDR_W'(32'h600); len = ADDR_W'(8); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (mem_valid !== 1'b1 || mem_write !== 1'b0 || mem_addr !== ADDR_W'(32'h501))
         $display("FAIL reset_mid_pre: got v%0b w%0b a%0h expected v1 w0 a501", mem_valid, mem_write, mem_addr);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (mem_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_mid_async: got valid%0b busy%0b expected 0 0", mem_valid, busy);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({busy, done, error, mem_valid, mem_write} !== 5'b0 || words_done !== '0 ||
          mem_addr !== '0 || mem_wdata !== '0)
         $display("FAIL reset_mid_idle: got busy%0b done%0b err%0b v%0b w%0b wd%0h a%0h d%0h expected all 0",
                  busy, done, error, mem_valid, mem_write, words_done, mem_addr, mem_wdata);
      else n_pass++;
      ref_mem[32'h600] = w0;
      nd = mem_diffs(first);
      n_total++;
      if (nd !== 0) $display("FAIL reset_mid_memory: %0d words differ, first at %0h", nd, first);
      else n_pass++;
      $display("txn reset_mid src=500 dst=600 len=8 partial=1");
      run_copy("after_reset", 32'h500, 32'h700, 8, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      for (int t = 0; t < 14; t++) begin
         int n, src, dst, mode, ab;
         n    = $urandom_range(1, 16);
         src  = $urandom_range(64, MEM_WORDS - 64);
         mode = $urandom_range(0, 3);
         case (mode)
            0:       dst = $urandom_range(64, MEM_WORDS - 64);
            1:       dst = src + $urandom_range(1, n);
            2:       dst = src - $urandom_range(1, n);
            default: dst = MEM_WORDS - n + $urandom_range(1, n);
         endcase
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : 0;
         preload_rand(src, n);
         run_copy($sformatf("rand%0d", t), src, dst, n, ab, 1'b0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic_copy();
      test_len_zero();
      test_overlap();
      test_range_error();
      test_abort();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
